// File: rtl/s16_mc_ctrl.sv
// Multi-cycle sequencer for the S16_MC datapath. Latency: 3 to 5 cycles per instruction, plus one cycle per memory stall.
// Stalls in FETCH/MEM_RD/MEM_WR until mem_ready, with strobes held. HALT is absorbing until reset.
module s16_mc_ctrl #(
  parameter int OPW   = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPW-1:0]   opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic [3:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'h0,
    S_DECODE   = 4'h1,
    S_EXEC_R   = 4'h2,
    S_EXEC_I   = 4'h3,
    S_MEM_ADDR = 4'h4,
    S_MEM_RD   = 4'h5,
    S_MEM_WR   = 4'h6,
    S_WB_R     = 4'h7,
    S_WB_I     = 4'h8,
    S_WB_MEM   = 4'h9,
    S_BRANCH   = 4'hA,
    S_JUMP     = 4'hB,
    S_HALT     = 4'hF
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  state_t             state_q, state_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic [3:0]         op;

  assign op = opcode[3:0];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // Next-state, sticky illegal flag and retire counter.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retired_d = retired_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          4'h0, 4'h1, 4'h2, 4'h3: state_d = S_EXEC_R;
          4'h4:                   state_d = S_EXEC_I;
          4'h5, 4'h6:             state_d = S_MEM_ADDR;
          4'h7:                   state_d = S_BRANCH;
          4'h8:                   state_d = S_JUMP;
          4'hF:                   state_d = S_HALT;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = (op == 4'h5) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        if (mem_ready) state_d = S_FETCH;
      end
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    // An instruction retires exactly when control returns to FETCH from elsewhere.
    if ((state_q != S_FETCH) && (state_d == S_FETCH)) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  // Control outputs decoded from the current state.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALU_ADD;
    pc_src     = PCSRC_ALU;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_ONE;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        alu_op    = op[1:0];
      end
      S_EXEC_I, S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_WB_I: begin
        reg_write = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        alu_op    = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_write  = zero;
      end
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      default: ;
    endcase
    // While reset is held the state reads FETCH, but no strobe may reach the datapath.
    if (!reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign state   = state_q;
  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_s16_mc_ctrl.sv
// Bench for s16_mc_ctrl: per-cycle expected state/controls/counters queued with the stimulus,
// popped and compared mid-cycle while the DUT runs each instruction.
module tb_s16_mc_ctrl;

  localparam int CW = 4;

  localparam logic [14:0] C_PCW   = 15'h4000;
  localparam logic [14:0] C_IRW   = 15'h2000;
  localparam logic [14:0] C_MRD   = 15'h1000;
  localparam logic [14:0] C_MWR   = 15'h0800;
  localparam logic [14:0] C_IORD  = 15'h0400;
  localparam logic [14:0] C_RW    = 15'h0200;
  localparam logic [14:0] C_RD    = 15'h0100;
  localparam logic [14:0] C_M2R   = 15'h0080;
  localparam logic [14:0] C_SA    = 15'h0040;
  localparam logic [14:0] C_SBONE = 15'h0010;
  localparam logic [14:0] C_SBIMM = 15'h0020;
  localparam logic [14:0] C_SUB   = 15'h0004;
  localparam logic [14:0] C_PSOUT = 15'h0001;
  localparam logic [14:0] C_PSJMP = 15'h0002;
  localparam logic [14:0] C_STRB  = C_PCW | C_IRW | C_MRD | C_MWR | C_RW;

  logic clk, reset, zero, mem_ready;
  logic [3:0] opcode;
  logic pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;
  logic halted, illegal;
  logic [CW-1:0] retired;
  logic [14:0] obs_ctl;

  s16_mc_ctrl #(.OPW(4), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .state(state), .halted(halted), .illegal(illegal), .retired(retired)
  );

  assign obs_ctl = {pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst,
                    mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mr;
    logic        zr;
    logic [3:0]  op;
    logic [3:0]  st;
    logic [14:0] ctl;
    logic [CW-1:0] ret;
    logic [1:0]  flg;
  } rec_t;

  rec_t sb_q[$];
  int n_chk = 0;
  int n_bad = 0;
  logic [CW-1:0] exp_ret;
  logic exp_ill;
  logic [3:0] cur_op;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic mr, input logic zr, input logic [3:0] st, input logic [14:0] c);
    rec_t r;
    r.mr = mr; r.zr = zr; r.op = cur_op; r.st = st; r.ctl = c;
    r.ret = exp_ret; r.flg = {(st == 4'hF), exp_ill};
    sb_q.push_back(r);
  endtask

  task automatic drain();
    rec_t r;
    while (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      @(negedge clk);
      mem_ready = r.mr; zero = r.zr; opcode = r.op;
      #1;
      chk("state", 32'(state), 32'(r.st));
      chk("ctl", 32'(obs_ctl), 32'(r.ctl));
      chk("retired", 32'(retired), 32'(r.ret));
      chk("halted_illegal", 32'({halted, illegal}), 32'(r.flg));
    end
  endtask

  task automatic push_fetch(input int fs);
    for (int i = 0; i < fs; i++) push(1'b0, rb(), 4'h0, C_MRD | C_SBONE);
    push(1'b1, rb(), 4'h0, C_MRD | C_SBONE | C_PCW | C_IRW);
    push(rb(), rb(), 4'h1, C_SBIMM);
  endtask

  task automatic run_instr(input logic [3:0] op, input logic zr, input int fs, input int ms);
    cur_op = op;
    push_fetch(fs);
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3: begin
        push(rb(), rb(), 4'h2, C_SA | (15'(op[1:0]) << 2));
        push(rb(), rb(), 4'h7, C_RW | C_RD);
      end
      4'h4: begin
        push(rb(), rb(), 4'h3, C_SA | C_SBIMM);
        push(rb(), rb(), 4'h8, C_RW);
      end
      4'h5: begin
        push(rb(), rb(), 4'h4, C_SA | C_SBIMM);
        for (int i = 0; i < ms; i++) push(1'b0, rb(), 4'h5, C_MRD | C_IORD);
        push(1'b1, rb(), 4'h5, C_MRD | C_IORD);
        push(rb(), rb(), 4'h9, C_RW | C_M2R);
      end
      4'h6: begin
        push(rb(), rb(), 4'h4, C_SA | C_SBIMM);
        for (int i = 0; i < ms; i++) push(1'b0, rb(), 4'h6, C_MWR | C_IORD);
        push(1'b1, rb(), 4'h6, C_MWR | C_IORD);
      end
      4'h7: push(rb(), zr, 4'hA, C_SA | C_SUB | C_PSOUT | (zr ? C_PCW : 15'h0));
      default: push(rb(), rb(), 4'hB, C_PSJMP | C_PCW);
    endcase
    exp_ret = exp_ret + 1'b1;
  endtask

  task automatic run_halt(input logic [3:0] op, input int n);
    cur_op = op;
    push_fetch(0);
    if (op != 4'hF) exp_ill = 1'b1;
    for (int i = 0; i < n; i++) push(rb(), rb(), 4'hF, 15'h0);
  endtask

  // Asserts reset mid-cycle, checks the immediate effect, releases just after a rising edge.
  task automatic apply_reset();
    mem_ready = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    exp_ret = '0;
    exp_ill = 1'b0;
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_strobes", 32'(obs_ctl & C_STRB), 32'h0);
    chk("rst_retired", 32'(retired), 32'h0);
    chk("rst_flags", 32'({halted, illegal}), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = 4'h0;
    exp_ret = '0; exp_ill = 1'b0; cur_op = 4'h0;
    #1 reset = 1'b0;
    #10;
    apply_reset();

    // 17 jumps wrap the 4-bit counter to 1.
    for (int i = 0; i < 17; i++) run_instr(4'h8, 1'b0, 0, 0);
    drain();
    @(posedge clk); #1;
    chk("wrap_retired", 32'(retired), 32'h1);

    // R-types, ADDI, then stalled SW and LW, then both branch outcomes.
    for (int i = 0; i < 4; i++) run_instr(4'(i), 1'b0, 0, 0);
    run_instr(4'h4, 1'b0, 0, 0);
    run_instr(4'h6, 1'b0, 1, 2);
    run_instr(4'h5, 1'b0, 2, 3);
    run_instr(4'h7, 1'b0, 0, 0);
    run_instr(4'h7, 1'b1, 0, 0);
    drain();

    // Random legal mix with random stalls.
    for (int i = 0; i < 25; i++) begin
      run_instr(4'($urandom_range(0, 8)), rb(), $urandom_range(0, 2), $urandom_range(0, 2));
    end
    drain();

    // LW abandoned by reset while stalled in MEM_RD.
    cur_op = 4'h5;
    push_fetch(0);
    push(rb(), rb(), 4'h4, C_SA | C_SBIMM);
    push(1'b0, rb(), 4'h5, C_MRD | C_IORD);
    drain();
    apply_reset();
    run_instr(4'h0, 1'b0, 0, 0);
    drain();

    // Illegal opcode, then a clean HALT after reset.
    run_halt(4'hC, 20);
    drain();
    apply_reset();
    run_halt(4'hF, 5);
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
